lcd_fetch_ctrl: RTL and testbench

Frame-fetch controller that feeds the LCD timing generator from the SDRAM frame buffer. It starts a frame on the driver's frame-begin pulse and issues fixed-length burst reads to the SDRAM read port through a req/ack handshake. Returned pixels are buffered in a local FIFO, and one RGB565 word is served per `lcd_request` cycle with one-cycle latency. It sits between the SDRAM read arbiter port and `lcd_driver`.

---
 rtl/lcd_fetch_pkg.sv | 31 +++
 rtl/lcd_fetch_ctrl_if.sv | 13 +
 rtl/lcd_pix_fifo.sv | 57 +++++
 rtl/lcd_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_lcd_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_fetch_pkg.sv
// Shared types and geometry helpers for the LCD frame-fetch controller.
package lcd_fetch_pkg;

  localparam int unsigned PIX_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StRecv,
    StDone
  } state_t;

  function automatic int unsigned frame_words(input int unsigned h_disp, input int unsigned v_disp);
    return h_disp * v_disp;
  endfunction

  function automatic int unsigned bursts_per_frame(input int unsigned h_disp,
                                                   input int unsigned v_disp,
                                                   input int unsigned burst_len);
    return frame_words(h_disp, v_disp) / burst_len;
  endfunction

  // Bursts must tile the frame exactly and the FIFO must hold two bursts.
  function automatic bit params_ok(input int unsigned h_disp, input int unsigned v_disp,
                                   input int unsigned burst_len, input int unsigned depth);
    return (burst_len != 0) && ((frame_words(h_disp, v_disp) % burst_len) == 0) &&
           (depth >= 2 * burst_len) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/lcd_fetch_ctrl_if.sv
// SDRAM read-port bundle between the fetch controller (master) and the read arbiter (slave).
interface lcd_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [15:0]       rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_valid, output rd_data);
endinterface

// File: rtl/lcd_pix_fifo.sv
// Pixel FIFO with flush; read data is registered and reads zero when popped while empty.
module lcd_pix_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CntW-1:0]  count,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && (count_q != CntW'(DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_data  <= '0;
    end else begin
      // Read port still sees the pre-flush head when pop and flush coincide.
      if (pop) rd_data <= do_pop ? mem_q[rd_ptr_q] : '0;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/lcd_fetch_ctrl.sv
// Frame-fetch controller: burst-reads the frame buffer into a pixel FIFO for lcd_driver.
module lcd_fetch_ctrl
  import lcd_fetch_pkg::*;
#(
  parameter int unsigned H_DISP     = 480,
  parameter int unsigned V_DISP     = 272,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             lcd_request,
  output logic [PIX_W-1:0] lcd_data,
  lcd_fetch_ctrl_if.master rd,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             underflow
);
  localparam int unsigned Bpf   = bursts_per_frame(H_DISP, V_DISP, BURST_LEN);
  localparam int unsigned BcW   = $clog2(Bpf + 1);
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  if (!params_ok(H_DISP, V_DISP, BURST_LEN, FIFO_DEPTH)) begin : g_bad_params
    $error("lcd_fetch_ctrl: BURST_LEN must divide the frame, FIFO_DEPTH pow2 >= 2*BURST_LEN");
  end

  state_t            state_q, state_d;
  logic [BcW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              pend_q, pend_d;
  logic              uf_q, uf_d;
  logic              restart, fifo_push, fifo_empty;
  logic [CntW-1:0]   fifo_count;

  assign rd.rd_req  = (state_q == StReq);
  assign rd.rd_addr = addr_q;
  assign frame_busy = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign underflow  = uf_q;
  // Beats of a burst overtaken by a restart are absorbed but never stored.
  assign fifo_push  = (state_q == StRecv) && rd.rd_valid && !pend_q;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    pend_d      = pend_q;
    restart     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          restart = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (frame_start)                           restart = 1'b1;
        else if (burst_cnt_q == BcW'(Bpf))         state_d = StDone;
        else if (fifo_count <= CntW'(FIFO_DEPTH - BURST_LEN)) state_d = StReq;
      end
      StReq: begin
        if (frame_start) pend_d = 1'b1;
        if (rd.rd_ack) begin
          state_d = StRecv;
          beat_d  = '0;
        end
      end
      StRecv: begin
        if (frame_start) pend_d = 1'b1;
        if (rd.rd_valid) begin
          beat_d = beat_q + BeatW'(1);
          if (beat_q == BeatW'(BURST_LEN - 1)) begin
            state_d = StCheck;
            if (pend_q || frame_start) begin
              restart = 1'b1;
            end else begin
              burst_cnt_d = burst_cnt_q + BcW'(1);
              addr_d      = addr_q + ADDR_W'(BURST_LEN);
            end
          end
        end
      end
      StDone: begin
        restart = frame_start;
        state_d = frame_start ? StCheck : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (restart) begin
      burst_cnt_d = '0;
      addr_d      = FRAME_BASE;
      pend_d      = 1'b0;
    end
    uf_d = uf_q;
    if (frame_start)                     uf_d = 1'b0;
    else if (lcd_request && fifo_empty)  uf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      addr_q      <= FRAME_BASE;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      uf_q        <= uf_d;
    end
  end

  lcd_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (restart),
    .push      (fifo_push),
    .push_data (rd.rd_data),
    .pop       (lcd_request),
    .rd_data   (lcd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_lcd_fetch_ctrl.sv
// Self-checking bench for lcd_fetch_ctrl: directed vectors plus a randomized full-frame run.
module tb_lcd_fetch_ctrl;
  localparam int unsigned H      = 32;
  localparam int unsigned V      = 8;
  localparam int unsigned BL     = 16;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 24;
  localparam int unsigned WORDS  = H * V;
  localparam int unsigned BURSTS = WORDS / BL;

  logic        clk = 1'b0;
  logic        rst, frame_start, lcd_request;
  logic [15:0] lcd_data;
  logic        frame_busy, frame_done, underflow;

  lcd_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  lcd_fetch_ctrl #(
    .H_DISP     (H),
    .V_DISP     (V),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .FRAME_BASE ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .lcd_request (lcd_request),
    .lcd_data    (lcd_data),
    .rd          (bus),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fs;
    logic        ack;
    logic        valid;
    logic [15:0] data;
    logic        req;
    logic        exp_req;
    logic [23:0] exp_addr;
    logic        exp_busy;
    logic [15:0] exp_lcd;
    logic        exp_uf;
  } vec_t;

  vec_t vecs [9];

  int n_checks = 0;
  int n_errors = 0;

  // Arbiter / pixel-consumer model state for the randomized run.
  int          beats_left, ack_wait, bursts, exp_word, avail, done_cnt, n_pix;
  bit          pend_check, drv_en, uf_seen, finished;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic fs, input logic ack, input logic valid, input logic [15:0] data,
                      input logic req);
    frame_start  = fs;
    bus.rd_ack   = ack;
    bus.rd_valid = valid;
    bus.rd_data  = data;
    lcd_request  = req;
    @(negedge clk);
    frame_start  = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.rd_valid = 1'b0;
    lcd_request  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " rd_req"}, 32'(bus.rd_req), 32'd0);
    chk({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, " frame_busy"}, 32'(frame_busy), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " underflow"}, 32'(underflow), 32'd0);
    chk({tag, " lcd_data"}, 32'(lcd_data), 32'd0);
  endtask

  // One negedge-to-negedge step of the arbiter and lcd_driver models.
  task automatic auto_cycle();
    bit beat;
    if (pend_check) begin
      chk($sformatf("pixel %0d", n_pix), 32'(lcd_data), 32'(exp_q.pop_front()));
      pend_check = 1'b0;
      n_pix++;
    end
    if (frame_done) done_cnt++;
    if (underflow) uf_seen = 1'b1;
    beat         = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.rd_valid = 1'b0;
    if (beats_left > 0) begin
      if ($urandom_range(3) != 0) begin
        beat         = 1'b1;
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'(exp_word);
        exp_q.push_back(16'(exp_word));
        exp_word++;
        beats_left--;
      end
    end else if (bus.rd_req) begin
      if (ack_wait == 0) begin
        chk($sformatf("burst %0d rd_addr", bursts), 32'(bus.rd_addr), 32'(bursts * BL));
        bus.rd_ack = 1'b1;
        beats_left = BL;
        bursts++;
        ack_wait   = int'($urandom_range(3));
      end else begin
        ack_wait--;
      end
    end
    lcd_request = 1'b0;
    if (drv_en && avail > 0 && $urandom_range(1) == 1) begin
      lcd_request = 1'b1;
      avail--;
      pend_check = 1'b1;
    end
    if (beat) avail++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; lcd_request = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;

    //            fs    ack   vld   data      req   rq    addr    busy  lcd       uf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 24'd0, 1'b1, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 24'd0, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 24'd0, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 24'd0, 1'b1, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 24'd0, 1'b1, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0, 24'd0, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 24'd0, 1'b1, 16'hA000, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 24'd0, 1'b1, 16'hA000, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 1'b0, 24'd0, 1'b1, 16'hA000, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // First burst: frame_start -> rd_req two cycles later, empty-read underflow, pops.
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].fs, vecs[i].ack, vecs[i].valid, vecs[i].data, vecs[i].req);
      chk($sformatf("vec%0d rd_req", i), 32'(bus.rd_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d rd_addr", i), 32'(bus.rd_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d busy", i), 32'(frame_busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d lcd_data", i), 32'(lcd_data), 32'(vecs[i].exp_lcd));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
    end
    for (int i = 3; i < BL; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'hA000 + i), 1'b0);
    chk("gap after burst0 rd_req", 32'(bus.rd_req), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("second req rd_req", 32'(bus.rd_req), 32'd1);
    chk("second req rd_addr", 32'(bus.rd_addr), 32'd16);

    // Restart during beat 5 of the second burst.
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'hC000 + i), 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'hC005, 1'b0);
    chk("restart underflow cleared", 32'(underflow), 32'd0);
    chk("restart still receiving", 32'(bus.rd_req), 32'd0);
    for (int i = 6; i < BL; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'hC000 + i), 1'b0);
    chk("restart gap rd_req", 32'(bus.rd_req), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("restart req rd_req", 32'(bus.rd_req), 32'd1);
    chk("restart req rd_addr", 32'(bus.rd_addr), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("flushed fifo lcd_data", 32'(lcd_data), 32'd0);
    chk("flushed fifo underflow", 32'(underflow), 32'd1);

    // Fresh burst after restart, then reset while in REQ.
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < BL; i++) tick(1'b0, 1'b0, 1'b1, 16'(16'hB000 + i), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("post-restart pop lcd_data", 32'(lcd_data), 32'hB000);
    chk("post-restart rd_req", 32'(bus.rd_req), 32'd1);
    chk("post-restart rd_addr", 32'(bus.rd_addr), 32'd16);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst in REQ");
    rst = 1'b0;
    @(negedge clk);
    chk("idle after rst rd_req", 32'(bus.rd_req), 32'd0);

    // Stalled pixel side, then a full randomized frame.
    beats_left = 0; ack_wait = 0; bursts = 0; exp_word = 0; avail = 0;
    done_cnt = 0; n_pix = 0; pend_check = 1'b0; drv_en = 1'b0; uf_seen = 1'b0;
    exp_q.delete();
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 200; c++) auto_cycle();
    chk("stall bursts", 32'(bursts), 32'd4);
    chk("stall rd_req", 32'(bus.rd_req), 32'd0);
    chk("stall busy", 32'(frame_busy), 32'd1);

    drv_en   = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      auto_cycle();
      finished = (bursts == BURSTS) && (beats_left == 0) && (exp_q.size() == 0) &&
                 !pend_check && (done_cnt > 0) && !frame_busy;
    end
    chk("frame completed in budget", 32'(finished), 32'd1);
    for (int c = 0; c < 5; c++) auto_cycle();
    chk("frame bursts", 32'(bursts), 32'(BURSTS));
    chk("frame_done pulses", 32'(done_cnt), 32'd1);
    chk("frame pixels", 32'(n_pix), 32'(WORDS));
    chk("frame underflow", 32'(uf_seen), 32'd0);
    chk("frame busy at end", 32'(frame_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
